// File: rtl/segment_to_binary_scanner.sv
// Decodes a 4-digit multiplexed active-low 7-segment bus back into hex digits once each pattern is stable.
// Optional macro SEG_TIMEOUT_EN adds per-digit staleness timeouts after TIMEOUT_CYCLES without a capture.
module segment_to_binary_scanner #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg_n,
   input  logic [3:0]  an_n,
   output logic [15:0] digits,
   output logic [3:0]  valid,
   output logic [3:0]  blank,
   output logic        err,
   output logic        frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;

   localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

   if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 24'hFFFFFF) begin : g_illegal_params
      $error("segment_to_binary_scanner: parameter out of range");
   end

   state_t      state, state_nx;
   logic [6:0]  r_seg, p_seg;
   logic [3:0]  r_an, p_an;
   logic [7:0]  cnt, cnt_nx;
   logic        same, capture, one_hot, hex_hit, is_blank;
   logic [3:0]  an_low, hex_val, seen, seen_nx, valid_nx, blank_nx;
   logic [15:0] digits_nx;
   logic        err_nx, fd_nx;

   // Input registers and the previous sample; idle value is all ones (everything dark)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg <= 7'h7f;
         r_an  <= 4'hf;
         p_seg <= 7'h7f;
         p_an  <= 4'hf;
         cnt   <= 8'd0;
      end else begin
         r_seg <= seg_n;
         r_an  <= an_n;
         p_seg <= r_seg;
         p_an  <= r_an;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      same   = ({r_an, r_seg} == {p_an, p_seg});
      cnt_nx = same ? ((cnt == StableMax) ? cnt : cnt + 8'd1) : 8'd1;
      an_low  = ~r_an;
      one_hot = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
      capture = (state == S_TRACK) && (r_an != 4'hf) && same && (cnt_nx == StableMax);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // HOLD blocks recapture of an unchanged pattern; any change restarts tracking
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (r_an != 4'hf) state_nx = S_TRACK;
         S_TRACK: begin
            if (r_an == 4'hf) state_nx = S_IDLE;
            else if (capture) state_nx = S_HOLD;
         end
         S_HOLD:  if (!same) state_nx = (r_an == 4'hf) ? S_IDLE : S_TRACK;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      hex_hit = 1'b1;
      hex_val = 4'h0;
      case (r_seg)
         7'b1000000: hex_val = 4'h0;
         7'b1111001: hex_val = 4'h1;
         7'b0100100: hex_val = 4'h2;
         7'b0110000: hex_val = 4'h3;
         7'b0011001: hex_val = 4'h4;
         7'b0010010: hex_val = 4'h5;
         7'b0000010: hex_val = 4'h6;
         7'b1111000: hex_val = 4'h7;
         7'b0000000: hex_val = 4'h8;
         7'b0010000: hex_val = 4'h9;
         7'b0001000: hex_val = 4'hA;
         7'b0000011: hex_val = 4'hB;
         7'b1000110: hex_val = 4'hC;
         7'b0100001: hex_val = 4'hD;
         7'b0000110: hex_val = 4'hE;
         7'b0001110: hex_val = 4'hF;
         default:    hex_hit = 1'b0;
      endcase
      is_blank = (r_seg == 7'h7f);
   end

`ifdef SEG_TIMEOUT_EN
   localparam logic [23:0] TimeoutLimit = 24'(TIMEOUT_CYCLES);

   logic [23:0] tcnt [4];
   logic [3:0]  cap_hit, expired;

   always_comb begin
      cap_hit = (capture && one_hot) ? an_low : 4'd0;
      for (int i = 0; i < 4; i++) expired[i] = (tcnt[i] == TimeoutLimit) && !cap_hit[i];
   end

   // Each digit's counter parks at the limit until that digit is captured again
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) tcnt[i] <= 24'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (cap_hit[i])                   tcnt[i] <= 24'd0;
            else if (tcnt[i] != TimeoutLimit) tcnt[i] <= tcnt[i] + 24'd1;
         end
      end
   end
`endif

   // Capture update: one capture per cycle at most, so err and frame_done never coincide
   always_comb begin
      digits_nx = digits;
      valid_nx  = valid;
      blank_nx  = blank;
      seen_nx   = seen;
      err_nx    = 1'b0;
      fd_nx     = 1'b0;
      if (capture) begin
         if (!one_hot) begin
            err_nx = 1'b1;
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (an_low[i]) begin
                  if (hex_hit) begin
                     digits_nx[4*i +: 4] = hex_val;
                     valid_nx[i] = 1'b1;
                     blank_nx[i] = 1'b0;
                     seen_nx[i]  = 1'b1;
                  end else if (is_blank) begin
                     valid_nx[i] = 1'b0;
                     blank_nx[i] = 1'b1;
                     seen_nx[i]  = 1'b1;
                  end else begin
                     err_nx      = 1'b1;
                     valid_nx[i] = 1'b0;
                     blank_nx[i] = 1'b0;
                  end
               end
            end
            if (seen_nx == 4'hf) begin
               fd_nx   = 1'b1;
               seen_nx = 4'd0;
            end
         end
      end
`ifdef SEG_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         if (expired[i]) begin
            valid_nx[i] = 1'b0;
            blank_nx[i] = 1'b0;
            seen_nx[i]  = 1'b0;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits     <= 16'd0;
         valid      <= 4'd0;
         blank      <= 4'd0;
         seen       <= 4'd0;
         err        <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         digits     <= digits_nx;
         valid      <= valid_nx;
         blank      <= blank_nx;
         seen       <= seen_nx;
         err        <= err_nx;
         frame_done <= fd_nx;
      end
   end

endmodule

// File: doc/segment_to_binary_scanner.md
Name: segment_to_binary_scanner

Overview:
- Receive-side counterpart of the hex-to-7-segment driver.
- Samples a 4-digit time-multiplexed, active-low 7-segment bus (segment lines plus anode strobes), waits for each pattern to be stable, and decodes it back to a 4-bit hex value per digit.
- Used for display loopback checking and for reading external display boards into the fabric.

Parameters:
- STABLE_CYCLES, 4, consecutive identical registered samples needed before capture; legal 2..255.
- TIMEOUT_CYCLES, 65535, cycles without a refresh before a digit goes stale. Used only with SEG_TIMEOUT_EN; legal 1..2^24-1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- seg_n  input  7  segment lines, active-low; bit6=G, bit0=A.
- an_n  input  4  digit anode strobes, active-low; bit i selects digit i.
- digits  output  16  decoded values; digits[4i+3:4i] = digit i.
- valid  output  4  valid[i]=1 when digits slice i holds a decoded hex value.
- blank  output  4  blank[i]=1 when digit i was last seen dark.
- err  output  1  one-cycle pulse on a stable illegal pattern or illegal anode combination.
- frame_done  output  1  one-cycle pulse when all 4 digits have been captured since the last pulse.

Behaviour:
- Reset (async, active-high):
  - digits=0, valid=0, blank=0, err=0, frame_done=0.
  - Input registers=all ones (inactive); stability counter=0; seen mask=0; FSM=S_IDLE.
- Input stage: seg_n and an_n are registered once (r_seg, r_an), then compared with the previous registered sample each cycle.
- Stability counter: increments, saturating at STABLE_CYCLES, while {r_an,r_seg} equals the previous sample; otherwise it loads 1.
- FSM:
  - S_IDLE: r_an==4'b1111. No capture. Leaves to S_TRACK when any anode is low.
  - S_TRACK: counting. When the count reaches STABLE_CYCLES, perform capture and go to S_HOLD.
  - S_HOLD: no recapture while inputs are unchanged. On any change go to S_TRACK (anode low) or S_IDLE (all high).
- Latency: edge 0 is the first edge that registers a new {an_n,seg_n} held constant. The capture result is visible after edge STABLE_CYCLES (edge 4 at default).
- Capture with r_an one-hot-low, digit i:
  - Hex table (active-low, G..A):
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Match: digit i slice <= value, valid[i]=1, blank[i]=0, seen[i]=1.
  - 1111111: blank[i]=1, valid[i]=0, slice held, seen[i]=1.
  - Any other pattern: err pulse, valid[i]=0, blank[i]=0, slice held, seen unchanged.
- Capture with r_an having 2..4 bits low: err pulse only. No digit, valid or seen change.
- frame_done:
  - Pulses on the cycle after a capture makes seen==4'b1111; seen clears to 0 in that same update.
  - Recapturing an already-seen digit does not pulse.
- Simultaneous events: err and frame_done are never asserted in the same cycle, because one capture happens per cycle at most.
- Reset mid-scan: everything returns to reset values immediately; the partial frame is discarded.

Optional Feature:
- Macro: SEG_TIMEOUT_EN.
- Defined:
  - One 24-bit counter per digit, cleared on any capture for that digit (hex, blank or illegal pattern).
  - When a counter reaches TIMEOUT_CYCLES, valid[i] and blank[i] clear and seen[i] clears; digits slice is held.
  - The counter then stops until the next capture for that digit.
- Undefined: valid/blank hold indefinitely; no counters are synthesized.

Test Plan:
- Basic scan: an_n=1110 with seg_n=0110000, held 8 cycles, then 1101/0011001, 1011/0000011, 0111/1000110, each held 8 cycles -> digits=16'hCB43, valid=1111, blank=0000, one frame_done pulse 4 cycles after digit 3's edge 0.
- Ghosting: toggle seg_n between two patterns every 2 cycles on an_n=1110 (STABLE_CYCLES=4) -> no capture, valid stays 0000; then hold 0000010 -> digits[3:0]=6 after edge 4.
- Illegal input: an_n=1110 with seg_n=0101010 held -> single err pulse, valid[0]=0; an_n=1100 with legal seg held -> single err pulse, digits unchanged.
- Blank: an_n=1011 with seg_n=1111111 held -> blank[2]=1, valid[2]=0, digits[11:8] unchanged, seen[2] set.
- Reset mid-scan: assert reset after digits 0..1 captured -> all outputs 0 asynchronously; after release, a full 4-digit scan is needed for frame_done.
- With SEG_TIMEOUT_EN and TIMEOUT_CYCLES=100: capture digit 0 then idle 100 cycles -> valid[0] drops; without the macro, valid[0] holds.
